tuple_sum_ctrl: RTL and testbench
=================================

Name: tuple_sum_ctrl

Overview:
- Sequencer that owns the 256x8 signed-value ROM and performs an exhaustive pair search.
- On start, scans entries 0..N-1 and reports every index pair (i<j) with ROM[i]+ROM[j] equal to a signed target.
- Sits between the host/top-level and the ROM. It drives the ROM address and chip-select, and consumes the ROM's combinational read data.

Parameters:
- N, 8, number of ROM entries searched, starting at address 0; legal range 2..256
- DW, 8, ROM data width; entries and target are two's-complement signed
- AW, 8, ROM address width
- CW, 8, match counter width; saturates at 2^CW-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a search; sampled only in IDLE
- target  in  DW  signed target sum; latched on the accepted start
- rom_addr  out  AW  ROM address; 0 whenever rom_cs=0
- rom_cs  out  1  ROM chip-select
- rom_dout  in  DW  ROM read data, combinational from rom_addr/rom_cs
- busy  out  1  high in LOAD/SCAN states
- done  out  1  one-cycle pulse when the search completes
- match_valid  out  1  one-cycle pulse per matching pair
- match_i  out  AW  lower index of the most recent match (held)
- match_j  out  AW  upper index of the most recent match (held)
- match_count  out  CW  number of matches in the current/last search (held)

Behaviour:
- Reset (async, immediate):
  - State IDLE; rom_cs=0 and rom_addr=0.
  - busy, done, match_valid = 0; match_i, match_j, match_count = 0.
  - Internal i, j, a_reg and target_reg = 0.
- States:
  - IDLE: start=1 latches target, sets i=0, clears match_count to 0, and goes to LOAD.
  - LOAD: rom_cs=1, rom_addr=i; a_reg <= rom_dout; j <= i+1; go to SCAN.
  - SCAN: rom_cs=1, rom_addr=j.
    - Compare sext(a_reg)+sext(rom_dout) against sext(target_reg) at DW+1 bits, so there is no overflow aliasing; e.g. -128 + -128 never matches.
    - If j=N-1 and i=N-2, go to DONE.
    - Else if j=N-1, then i<=i+1 and go to LOAD.
    - Else j<=j+1 and stay in SCAN.
  - DONE: done=1 for exactly one cycle; rom_cs=0; return to IDLE.
- Match reporting:
  - An equal compare in a SCAN cycle registers at that cycle's closing edge.
  - Effect: match_valid=1, match_i=i, match_j=j, match_count+1 (saturating), all visible the following cycle.
  - match_valid is high for one cycle per match.
  - A match on the final SCAN cycle pulses match_valid in the same cycle as done.
- Latency:
  - busy rises the cycle after the start edge.
  - busy lasts (N-1) LOAD + N(N-1)/2 SCAN cycles: 35 cycles for N=8.
  - done is high the cycle after the last SCAN; busy is low in that cycle.
- start while busy or in DONE is ignored. target changes after acceptance have no effect.
- match_i, match_j and match_count hold until the next accepted start or reset. A new start clears match_count only; match_i/match_j keep their old values until the next match.
- Pair order is i ascending, then j ascending; i=j pairs are never evaluated.
- Reset asserted mid-search aborts immediately to the reset values; no done pulse.

Test Plan (ROM image addr0..7 = {-5,-2,3,2,0,-5,4,1}, N=8):
- Reset then target=0, start -> one match_valid with (i,j)=(1,3); done 36 cycles after the start edge; match_count=1; rom_cs low after done.
- target=-1 -> three matches in order (0,6), (1,7), (5,6); match_count=3; match_i/match_j hold (5,6) after done.
- target=5 -> matches (2,3) then (6,7). The (6,7) pulse coincides with done. match_count=2.
- target=127 -> no match_valid; match_count=0; busy exactly 35 cycles. Then start with target=-10 -> single match (0,5), count=1.
- start pulsed again during busy with target=5 (original search target=0) -> ignored; only the (1,3) result is reported and the cycle count is unchanged.
- Assert rst_n=0 on cycle 10 of a search -> rom_cs, busy and match_count go to 0 immediately, no done pulse. A new start after release runs a full, correct search.

Source files
------------

// File: rtl/tuple_sum_ctrl_if.sv
// ROM bus between the pair-search sequencer and the value ROM.
// The ROM answers combinationally from rom_addr/rom_cs.
interface tuple_sum_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [DW-1:0] rom_dout;

  modport master (
    output rom_addr,
    output rom_cs,
    input  rom_dout
  );

  modport slave (
    input  rom_addr,
    input  rom_cs,
    output rom_dout
  );
endinterface

// File: rtl/tuple_sum_ctrl.sv
// Exhaustive pair search over ROM[0..N-1]: reports every i<j
// whose signed sum equals the latched target.
module tuple_sum_ctrl #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] target,
  tuple_sum_ctrl_if.master rom,
  output logic          busy,
  output logic          done,
  output logic          match_valid,
  output logic [AW-1:0] match_i,
  output logic [AW-1:0] match_j,
  output logic [CW-1:0] match_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [AW-1:0] PENULT = AW'(N - 2);
  localparam logic [CW-1:0] CMAX   = {CW{1'b1}};

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] i;
  logic [AW-1:0] i_nxt;
  logic [AW-1:0] j;
  logic [AW-1:0] j_nxt;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] a_nxt;
  logic [DW-1:0] target_reg;
  logic [DW-1:0] tgt_nxt;
  logic          clr_count;

  logic [DW:0]   sum;
  logic [DW:0]   tgt_ext;
  logic          hit;

  // One extra bit keeps e.g. -128 + -128 from aliasing onto 0.
  assign sum     = {a_reg[DW-1], a_reg}
                 + {rom.rom_dout[DW-1], rom.rom_dout};
  assign tgt_ext = {target_reg[DW-1], target_reg};
  assign hit     = (state == SCAN) && (sum == tgt_ext);

  always_comb begin
    state_nxt    = state;
    i_nxt        = i;
    j_nxt        = j;
    a_nxt        = a_reg;
    tgt_nxt      = target_reg;
    clr_count    = 1'b0;
    rom.rom_cs   = 1'b0;
    rom.rom_addr = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          tgt_nxt   = target;
          i_nxt     = '0;
          clr_count = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        rom.rom_cs   = 1'b1;
        rom.rom_addr = i;
        busy         = 1'b1;
        a_nxt        = rom.rom_dout;
        j_nxt        = i + AW'(1);
        state_nxt    = SCAN;
      end
      SCAN: begin
        rom.rom_cs   = 1'b1;
        rom.rom_addr = j;
        busy         = 1'b1;
        if (j == LAST) begin
          if (i == PENULT) begin
            state_nxt = DONE;
          end else begin
            i_nxt     = i + AW'(1);
            state_nxt = LOAD;
          end
        end else begin
          j_nxt = j + AW'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      a_reg      <= '0;
      target_reg <= '0;
    end else begin
      state      <= state_nxt;
      i          <= i_nxt;
      j          <= j_nxt;
      a_reg      <= a_nxt;
      target_reg <= tgt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid <= 1'b0;
      match_i     <= '0;
      match_j     <= '0;
      match_count <= '0;
    end else begin
      match_valid <= hit;
      if (hit) begin
        match_i <= i;
        match_j <= j;
      end
      if (clr_count) begin
        match_count <= '0;
      end else if (hit && (match_count != CMAX)) begin
        match_count <= match_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tuple_sum_ctrl.sv
// Bench for tuple_sum_ctrl: table vectors on the reference ROM,
// hand sequences for restart/reset, random ROMs vs a pair model.
module tb_tuple_sum_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] target;
  logic       busy;
  logic       done;
  logic       match_valid;
  logic [7:0] match_i;
  logic [7:0] match_j;
  logic [7:0] match_count;

  logic signed [7:0] rom_mem [256];

  tuple_sum_ctrl_if #(.AW(8), .DW(8)) rom_bus ();

  always_comb begin
    rom_bus.rom_dout = rom_bus.rom_cs ? rom_mem[rom_bus.rom_addr] : 8'h00;
  end

  tuple_sum_ctrl #(.N(N), .DW(8), .AW(8), .CW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .target      (target),
    .rom         (rom_bus.master),
    .busy        (busy),
    .done        (done),
    .match_valid (match_valid),
    .match_i     (match_i),
    .match_j     (match_j),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int cnt;
    int p0;
    int p1;
    int p2;
  } vec_t;

  vec_t tbl [5];

  int n_pass  = 0;
  int n_total = 0;
  int got_q [$];
  int exp_q [$];
  int busy_n;
  int lat;
  int last_hold;
  logic done_seen;
  logic done_mv;

  task automatic chk(input string tag, input string nm,
                     input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d", tag, nm, got, exp);
  endtask

  task automatic load_ref_rom();
    int img [8] = '{-5, -2, 3, 2, 0, -5, 4, 1};
    for (int k = 0; k < 256; k++) rom_mem[k] = 8'sd0;
    for (int k = 0; k < 8; k++) rom_mem[k] = 8'(img[k]);
  endtask

  // Every i<j pair whose true integer sum hits the target, in scan order.
  task automatic model(input int tgt);
    exp_q.delete();
    for (int a = 0; a < N - 1; a++)
      for (int b = a + 1; b < N; b++)
        if (int'(rom_mem[a]) + int'(rom_mem[b]) == tgt)
          exp_q.push_back(a * 256 + b);
  endtask

  task automatic run_search(input int tgt, input int pulse_at,
                            input int pulse_tgt, input string tag);
    got_q.delete();
    busy_n    = 0;
    done_seen = 1'b0;
    done_mv   = 1'b0;
    target    = 8'(tgt);
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    target = 8'($urandom);
    lat    = 1;
    for (int k = 0; k < 2000; k++) begin
      if (busy) busy_n++;
      if (match_valid) got_q.push_back(int'(match_i) * 256 + int'(match_j));
      if (done) begin
        done_seen = 1'b1;
        done_mv   = match_valid;
        break;
      end
      if (lat == pulse_at) begin
        start  = 1'b1;
        target = 8'(pulse_tgt);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk(tag, "done_seen", int'(done_seen), 1);
    @(posedge clk); #1;
    chk(tag, "done_one_cycle", int'(done), 0);
    chk(tag, "cs_after_done", int'(rom_bus.rom_cs), 0);
    chk(tag, "addr_after_done", int'(rom_bus.rom_addr), 0);
    chk(tag, "busy_after_done", int'(busy), 0);
  endtask

  task automatic check_run(input string tag);
    chk(tag, "n_match", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk(tag, $sformatf("pair%0d", k),
          (k < got_q.size()) ? got_q[k] : -1, exp_q[k]);
    chk(tag, "match_count", int'(match_count), exp_q.size());
    chk(tag, "busy_cycles", busy_n, (N - 1) + N * (N - 1) / 2);
    chk(tag, "done_latency", lat, N + N * (N - 1) / 2);
    chk(tag, "done_with_match", int'(done_mv),
        int'(exp_q.size() > 0 && exp_q[$] == (N - 2) * 256 + (N - 1)));
    if (exp_q.size() > 0) last_hold = exp_q[$];
    chk(tag, "held_ij", int'(match_i) * 256 + int'(match_j), last_hold);
  endtask

  initial begin
    tbl[0] = '{0,   1, 1*256+3, 0,       0};
    tbl[1] = '{-1,  3, 0*256+6, 1*256+7, 5*256+6};
    tbl[2] = '{5,   2, 2*256+3, 6*256+7, 0};
    tbl[3] = '{127, 0, 0,       0,       0};
    tbl[4] = '{-10, 1, 0*256+5, 0,       0};

    load_ref_rom();
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 8'h00;
    last_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "busy", int'(busy), 0);
    chk("reset", "cs", int'(rom_bus.rom_cs), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset", "done", int'(done), 0);
    chk("reset", "match_valid", int'(match_valid), 0);
    chk("reset", "match_ij", int'(match_i) * 256 + int'(match_j), 0);
    chk("reset", "match_count", int'(match_count), 0);
    chk("reset", "addr", int'(rom_bus.rom_addr), 0);

    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      if (tbl[v].cnt > 0) exp_q.push_back(tbl[v].p0);
      if (tbl[v].cnt > 1) exp_q.push_back(tbl[v].p1);
      if (tbl[v].cnt > 2) exp_q.push_back(tbl[v].p2);
      run_search(tbl[v].tgt, 0, 0, $sformatf("vec%0d", v));
      check_run($sformatf("vec%0d", v));
    end

    // A start pulse with a different target while busy must be ignored.
    exp_q.delete();
    exp_q.push_back(1 * 256 + 3);
    run_search(0, 10, 5, "restart");
    check_run("restart");

    // Abort mid-search with an asynchronous reset.
    target = 8'hFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort", "count_before", int'(match_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort", "cs", int'(rom_bus.rom_cs), 0);
    chk("abort", "busy", int'(busy), 0);
    chk("abort", "match_count", int'(match_count), 0);
    chk("abort", "match_ij", int'(match_i) * 256 + int'(match_j), 0);
    begin
      int seen_done = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (done) seen_done++;
      end
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (done || busy) seen_done++;
      end
      chk("abort", "no_done", seen_done, 0);
    end
    last_hold = 0;
    model(-1);
    run_search(-1, 0, 0, "after_abort");
    check_run("after_abort");

    // -128 + -128 must not alias onto a zero target.
    for (int k = 0; k < N; k++) rom_mem[k] = -8'sd128;
    model(0);
    run_search(0, 0, 0, "neg_ext");
    check_run("neg_ext");

    for (int r = 0; r < 20; r++) begin
      int tgt;
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 5))
          0:       rom_mem[k] = -8'sd128;
          1:       rom_mem[k] = 8'sd127;
          default: rom_mem[k] = 8'($urandom_range(0, 255));
        endcase
      end
      tgt = int'(8'sh00) + $urandom_range(0, 255) - 128;
      if (r % 2 == 1) begin
        int a = $urandom_range(0, N - 2);
        int s = int'(rom_mem[a]) + int'(rom_mem[$urandom_range(a + 1, N - 1)]);
        if (s >= -128 && s <= 127) tgt = s;
      end
      model(tgt);
      run_search(tgt, 0, 0, $sformatf("rand%0d", r));
      check_run($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
